// File: rtl/ldxa_pkg.sv
// rtl/ldxa_pkg.sv - shared LDXA types, constants and the per-lane evaluation function
package ldxa_pkg;

    localparam int LDXA_LATENCY = 1;

    // Reference truth table indexed by {d,x,a}: bit n holds L for combination n.
    localparam logic [7:0] LDXA_TRUTH = 8'b1110_1010;

    function automatic logic ldxa_eval(input logic d, input logic x, input logic a);
        return (d & x) | a;
    endfunction

endpackage

// File: rtl/ldxa_if.sv
// rtl/ldxa_if.sv - operand/result bundle of the LDXA evaluator
interface ldxa_if #(
    parameter int WIDTH = 1
);
    logic             in_valid;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] a;
    logic             out_valid;
    logic [WIDTH-1:0] l;
    logic             l_any;

    modport master (
        output in_valid, d, x, a,
        input  out_valid, l, l_any
    );

    modport slave (
        input  in_valid, d, x, a,
        output out_valid, l, l_any
    );
endinterface

// File: rtl/ldxa_cell.sv
// rtl/ldxa_cell.sv - combinational single-lane LDXA evaluator
module ldxa_cell
    import ldxa_pkg::*;
(
    input  logic d,
    input  logic x,
    input  logic a,
    output logic l
);
    assign l = ldxa_eval(d, x, a);
endmodule

// File: rtl/ldxa_unit.sv
// rtl/ldxa_unit.sv - registered WIDTH-lane LDXA evaluator with saturating event counter
// Optional self-sweep of all eight {d,x,a} combinations under `LDXA_SWEEP_EN.
module ldxa_unit
    import ldxa_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    ldxa_if.slave            bus,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] l_count
`ifdef LDXA_SWEEP_EN
    ,
    input  logic             sweep_start,
    output logic             sweep_busy
`endif
);
    logic             eff_valid;
    logic [WIDTH-1:0] eff_d;
    logic [WIDTH-1:0] eff_x;
    logic [WIDTH-1:0] eff_a;
    logic [WIDTH-1:0] l_next;

`ifdef LDXA_SWEEP_EN
    logic [2:0] sweep_idx;

    // While sweeping, the counter owns every lane and the external operands are ignored.
    always_comb begin
        eff_valid = bus.in_valid;
        eff_d     = bus.d;
        eff_x     = bus.x;
        eff_a     = bus.a;
        if (sweep_busy) begin
            eff_valid = 1'b1;
            eff_d     = {WIDTH{sweep_idx[2]}};
            eff_x     = {WIDTH{sweep_idx[1]}};
            eff_a     = {WIDTH{sweep_idx[0]}};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sweep_busy <= 1'b0;
            sweep_idx  <= 3'd0;
        end else if (sweep_busy) begin
            if (sweep_idx == 3'd7) begin
                sweep_busy <= 1'b0;
            end
            sweep_idx <= sweep_idx + 3'd1;
        end else if (sweep_start) begin
            sweep_busy <= 1'b1;
            sweep_idx  <= 3'd0;
        end
    end
`else
    always_comb begin
        eff_valid = bus.in_valid;
        eff_d     = bus.d;
        eff_x     = bus.x;
        eff_a     = bus.a;
    end
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        ldxa_cell u_cell (
            .d (eff_d[i]),
            .x (eff_x[i]),
            .a (eff_a[i]),
            .l (l_next[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.l         <= '0;
            bus.l_any     <= 1'b0;
            l_count       <= '0;
        end else begin
            bus.out_valid <= eff_valid;
            // l holds across idle cycles; l_any drops so it never shows without out_valid.
            bus.l_any     <= eff_valid & (|l_next);
            if (eff_valid) begin
                bus.l <= l_next;
            end
            if (cnt_clr) begin
                l_count <= '0;
            end else if (eff_valid && (|l_next) && (l_count != {CNT_W{1'b1}})) begin
                l_count <= l_count + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_ldxa_unit.sv
// tb/tb_ldxa_unit.sv - directed table-driven bench for ldxa_unit
module tb_ldxa_unit;
    typedef struct {
        logic        v;
        logic        clr;
        logic [3:0]  d;
        logic [3:0]  x;
        logic [3:0]  a;
        logic        ov;
        logic [3:0]  l;
        logic        any;
        logic [15:0] cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic clr1, clr4, clrs;
    logic [15:0] cnt1, cnt4;
    logic [1:0]  cnts;
    int checks = 0;
    int errors = 0;

    ldxa_if #(.WIDTH(1)) if1 ();
    ldxa_if #(.WIDTH(4)) if4 ();
    ldxa_if #(.WIDTH(1)) ifs ();

`ifdef LDXA_SWEEP_EN
    logic ss1, ss4, sss, sb1, sb4, sbs;
    initial begin
        ss1 = 1'b0;
        ss4 = 1'b0;
        sss = 1'b0;
    end
`endif

    ldxa_unit #(.WIDTH(1), .CNT_W(16)) u_w1 (
        .clk(clk), .rst_n(rst_n), .bus(if1), .cnt_clr(clr1), .l_count(cnt1)
`ifdef LDXA_SWEEP_EN
        , .sweep_start(ss1), .sweep_busy(sb1)
`endif
    );

    ldxa_unit #(.WIDTH(4), .CNT_W(16)) u_w4 (
        .clk(clk), .rst_n(rst_n), .bus(if4), .cnt_clr(clr4), .l_count(cnt4)
`ifdef LDXA_SWEEP_EN
        , .sweep_start(ss4), .sweep_busy(sb4)
`endif
    );

    ldxa_unit #(.WIDTH(1), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .bus(ifs), .cnt_clr(clrs), .l_count(cnts)
`ifdef LDXA_SWEEP_EN
        , .sweep_start(sss), .sweep_busy(sbs)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_w1(input vec_t t);
        if1.in_valid = t.v;
        if1.d        = t.d[0];
        if1.x        = t.x[0];
        if1.a        = t.a[0];
        clr1         = t.clr;
    endtask

    task automatic drive_w4(input vec_t t);
        if4.in_valid = t.v;
        if4.d        = t.d;
        if4.x        = t.x;
        if4.a        = t.a;
        clr4         = t.clr;
    endtask

    task automatic check_w1(input string tag, input vec_t t);
        check({tag, ".out_valid"}, 64'(if1.out_valid), 64'(t.ov));
        if (t.ov) check({tag, ".l"}, 64'(if1.l), 64'(t.l[0]));
        check({tag, ".l_any"}, 64'(if1.l_any), 64'(t.any));
        check({tag, ".l_count"}, 64'(cnt1), 64'(t.cnt));
    endtask

    task automatic check_w4(input string tag, input vec_t t);
        check({tag, ".out_valid"}, 64'(if4.out_valid), 64'(t.ov));
        check({tag, ".l"}, 64'(if4.l), 64'(t.l));
        check({tag, ".l_any"}, 64'(if4.l_any), 64'(t.any));
        check({tag, ".l_count"}, 64'(cnt4), 64'(t.cnt));
    endtask

    vec_t t1[9];
    vec_t t4[6];
    int   sat_exp[5] = '{1, 2, 3, 3, 3};

    initial begin
        // WIDTH=1 exhaustive sweep of {d,x,a}, then an idle cycle with a=1 (l must hold).
        //         v     clr   d     x     a     ov    l     any   cnt
        t1[0] = '{1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 4'h0, 1'b0, 16'd0};
        t1[1] = '{1'b1, 1'b0, 4'h0, 4'h0, 4'h1, 1'b1, 4'h1, 1'b1, 16'd1};
        t1[2] = '{1'b1, 1'b0, 4'h0, 4'h1, 4'h0, 1'b1, 4'h0, 1'b0, 16'd1};
        t1[3] = '{1'b1, 1'b0, 4'h0, 4'h1, 4'h1, 1'b1, 4'h1, 1'b1, 16'd2};
        t1[4] = '{1'b1, 1'b0, 4'h1, 4'h0, 4'h0, 1'b1, 4'h0, 1'b0, 16'd2};
        t1[5] = '{1'b1, 1'b0, 4'h1, 4'h0, 4'h1, 1'b1, 4'h1, 1'b1, 16'd3};
        t1[6] = '{1'b1, 1'b0, 4'h1, 4'h1, 4'h0, 1'b1, 4'h1, 1'b1, 16'd4};
        t1[7] = '{1'b1, 1'b0, 4'h1, 4'h1, 4'h1, 1'b1, 4'h1, 1'b1, 16'd5};
        t1[8] = '{1'b0, 1'b0, 4'h0, 4'h0, 4'h1, 1'b0, 4'h1, 1'b0, 16'd5};

        // WIDTH=4 lane patterns, a hold cycle, and clear colliding with an increment.
        t4[0] = '{1'b1, 1'b0, 4'hC, 4'hA, 4'h1, 1'b1, 4'h9, 1'b1, 16'd1};
        t4[1] = '{1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 4'h0, 1'b0, 16'd1};
        t4[2] = '{1'b1, 1'b0, 4'h0, 4'h0, 4'hF, 1'b1, 4'hF, 1'b1, 16'd2};
        t4[3] = '{1'b1, 1'b0, 4'h6, 4'h7, 4'h8, 1'b1, 4'hE, 1'b1, 16'd3};
        t4[4] = '{1'b0, 1'b0, 4'hF, 4'hF, 4'hF, 1'b0, 4'hE, 1'b0, 16'd3};
        t4[5] = '{1'b1, 1'b1, 4'h1, 4'h1, 4'h0, 1'b1, 4'h1, 1'b1, 16'd0};

        rst_n = 1'b0;
        if1.in_valid = 1'b1; if1.d = '1; if1.x = '1; if1.a = '1; clr1 = 1'b0;
        if4.in_valid = 1'b1; if4.d = '1; if4.x = '1; if4.a = '1; clr4 = 1'b0;
        ifs.in_valid = 1'b1; ifs.d = '1; ifs.x = '1; ifs.a = '1; clrs = 1'b0;
        tick();
        tick();
        check("rst.w1.out_valid", 64'(if1.out_valid), 64'd0);
        check("rst.w1.l", 64'(if1.l), 64'd0);
        check("rst.w1.l_any", 64'(if1.l_any), 64'd0);
        check("rst.w1.l_count", 64'(cnt1), 64'd0);
        check("rst.w4.out_valid", 64'(if4.out_valid), 64'd0);
        check("rst.w4.l", 64'(if4.l), 64'd0);
        check("rst.w4.l_any", 64'(if4.l_any), 64'd0);
        check("rst.w4.l_count", 64'(cnt4), 64'd0);
        check("rst.sat.l_count", 64'(cnts), 64'd0);

        rst_n = 1'b1;
        if4.in_valid = 1'b0;
        ifs.in_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            drive_w1(t1[i]);
            tick();
            check_w1($sformatf("w1[%0d]", i), t1[i]);
        end
        if1.in_valid = 1'b0;

        for (int i = 0; i < 6; i++) begin
            drive_w4(t4[i]);
            tick();
            check_w4($sformatf("w4[%0d]", i), t4[i]);
        end

        // Saturation at 2^2-1 with CNT_W=2, then clear beating a same-edge increment.
        ifs.d = 1'b0; ifs.x = 1'b0; ifs.a = 1'b1; ifs.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("sat.cnt[%0d]", i), 64'(cnts), 64'(sat_exp[i]));
        end
        clrs = 1'b1;
        tick();
        check("sat.clr_wins", 64'(cnts), 64'd0);
        check("sat.clr_l", 64'(ifs.l), 64'd1);
        clrs = 1'b0;
        tick();
        check("sat.after_clr", 64'(cnts), 64'd1);
        ifs.in_valid = 1'b0;

        // Reset in the middle of continuous traffic, then recovery with one-cycle latency.
        clr4 = 1'b0;
        if4.in_valid = 1'b1; if4.d = 4'h0; if4.x = 4'h0; if4.a = 4'h3;
        tick();
        check("mid.pre.l", 64'(if4.l), 64'h3);
        check("mid.pre.cnt", 64'(cnt4), 64'd1);
        rst_n = 1'b0;
        tick();
        check("mid.rst.out_valid", 64'(if4.out_valid), 64'd0);
        check("mid.rst.l", 64'(if4.l), 64'd0);
        check("mid.rst.l_any", 64'(if4.l_any), 64'd0);
        check("mid.rst.cnt", 64'(cnt4), 64'd0);
        rst_n = 1'b1;
        if4.d = 4'hF; if4.x = 4'hF; if4.a = 4'h0;
        tick();
        check("mid.post.out_valid", 64'(if4.out_valid), 64'd1);
        check("mid.post.l", 64'(if4.l), 64'hF);
        check("mid.post.l_any", 64'(if4.l_any), 64'd1);
        check("mid.post.cnt", 64'(cnt4), 64'd1);
        if4.in_valid = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
